clk_div_prog: RTL and testbench

Runtime-programmable clock divider, the generalised successor to the fixed power-of-two toggle divider. It produces two outputs:
- a one-cycle clock-enable `tick` every D enabled cycles;
- a square wave `out` of period 2*D.

D is any W-bit value, reloadable at runtime through a shadow register that applies glitch-free at counter wrap. It sits between the board oscillator domain (single clk) and slow logic: blinkers, UART baud ticks, scan timers.

---
 rtl/clk_div_prog.sv | 134 +++++++++++++
 tb/tb_clk_div_prog.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_prog.sv
// Programmable clock divider: one-cycle tick every D enabled cycles plus a divided clock `out`
// (50% toggle of period 2*D, or a PWM of period D when CLK_DIV_DUTY_EN is defined).
// Outputs are registered (one edge after wrap); en=0 freezes counting, and loads wait in the shadow register until the next wrap.
module clk_div_prog #(
    parameter int W        = 24,
    parameter int DIV_INIT = 6000000
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [W-1:0] div_in,
    input  logic         div_load,
`ifdef CLK_DIV_DUTY_EN
    input  logic [W-1:0] duty,
`endif
    output logic         div_pending,
    output logic         tick,
    output logic         out
);

    localparam logic [W-1:0] DIV_RST = W'(DIV_INIT);
`ifdef CLK_DIV_DUTY_EN
    localparam logic [W-1:0] DUTY_RST = W'(DIV_INIT / 2);
`endif

    logic [W-1:0] cnt, cnt_nx;
    logic [W-1:0] div, div_nx;
    logic [W-1:0] shadow, shadow_nx;
    logic         pend_nx;
    logic         tick_nx;
    logic         out_nx;
    logic         halted;
    logic         wrap;

`ifdef CLK_DIV_DUTY_EN
    logic [W-1:0] duty_act, duty_act_nx;
    logic [W-1:0] duty_sh, duty_sh_nx;
`endif

    // D==0 is decoded on its own so div-1 is never evaluated as an underflow.
    assign halted = (div == '0);
    assign wrap   = en && !halted && (cnt == div - W'(1));

    always_comb begin
        cnt_nx    = cnt;
        div_nx    = div;
        shadow_nx = shadow;
        pend_nx   = div_pending;
        tick_nx   = 1'b0;
        out_nx    = out;
`ifdef CLK_DIV_DUTY_EN
        duty_act_nx = duty_act;
        duty_sh_nx  = duty_sh;
`endif
        if (halted) begin
            cnt_nx  = '0;
            out_nx  = 1'b0;
            pend_nx = 1'b0;
            if (div_load) begin
                div_nx = div_in;
`ifdef CLK_DIV_DUTY_EN
                duty_act_nx = duty;
`endif
            end
        end else begin
            if (div_load && !wrap) begin
                shadow_nx = div_in;
                pend_nx   = 1'b1;
`ifdef CLK_DIV_DUTY_EN
                duty_sh_nx = duty;
`endif
            end
            if (en) begin
                if (wrap) begin
                    cnt_nx  = '0;
                    tick_nx = 1'b1;
                    // A load coinciding with wrap bypasses the shadow entirely.
                    if (div_load) begin
                        div_nx  = div_in;
                        pend_nx = 1'b0;
`ifdef CLK_DIV_DUTY_EN
                        duty_act_nx = duty;
`endif
                    end else if (div_pending) begin
                        div_nx  = shadow;
                        pend_nx = 1'b0;
`ifdef CLK_DIV_DUTY_EN
                        duty_act_nx = duty_sh;
`endif
                    end
`ifndef CLK_DIV_DUTY_EN
                    out_nx = (div_nx == '0) ? 1'b0 : ~out;
`endif
                end else begin
                    cnt_nx = cnt + W'(1);
                end
`ifdef CLK_DIV_DUTY_EN
                out_nx = (div_nx == '0) ? 1'b0 : (cnt_nx < duty_act_nx);
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            div         <= DIV_RST;
            shadow      <= '0;
            div_pending <= 1'b0;
            tick        <= 1'b0;
            out         <= 1'b0;
        end else begin
            cnt         <= cnt_nx;
            div         <= div_nx;
            shadow      <= shadow_nx;
            div_pending <= pend_nx;
            tick        <= tick_nx;
            out         <= out_nx;
        end
    end

`ifdef CLK_DIV_DUTY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty_act <= DUTY_RST;
            duty_sh  <= '0;
        end else begin
            duty_act <= duty_act_nx;
            duty_sh  <= duty_sh_nx;
        end
    end
`endif

endmodule

// File: tb/tb_clk_div_prog.sv
// Directed bench for clk_div_prog with DIV_INIT=4; also covers the PWM variant when CLK_DIV_DUTY_EN is defined.
module tb_clk_div_prog;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         en = 1'b0;
    logic [W-1:0] div_in = '0;
    logic         div_load = 1'b0;
`ifdef CLK_DIV_DUTY_EN
    logic [W-1:0] duty = '0;
`endif
    logic         div_pending;
    logic         tick;
    logic         out;

    int errors = 0;
    int checks = 0;
    int hi;

    clk_div_prog #(.W(W), .DIV_INIT(4)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .en(en),
        .div_in(div_in),
        .div_load(div_load),
`ifdef CLK_DIV_DUTY_EN
        .duty(duty),
`endif
        .div_pending(div_pending),
        .tick(tick),
        .out(out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // The toggle-mode out expectations do not apply to the PWM build.
    task automatic chk_out(input string tag, input logic obs, input logic exp);
`ifndef CLK_DIV_DUTY_EN
        chk(tag, 32'(obs), 32'(exp));
`endif
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        en = 1'b1;
        #3;
        chk("rst_tick", 32'(tick), 0);
        chk("rst_out", 32'(out), 0);
        chk("rst_pend", 32'(div_pending), 0);
        step(); step();
        chk("rst_hold_tick", 32'(tick), 0);
        chk("rst_hold_out", 32'(out), 0);
        rst_n = 1'b1;

        // D=4 free-running
        for (int k = 1; k <= 16; k++) begin
            step();
            chk("t1_tick", 32'(tick), 32'(k % 4 == 0));
            chk_out("t1_out", out, 1'((k / 4) % 2));
        end

        // load 10 at cnt=1
        step();
        div_in = 8'd10; div_load = 1'b1; step(); div_load = 1'b0;
        chk("t2_pend_a", 32'(div_pending), 1);
        chk("t2_tick_a", 32'(tick), 0);
        step();
        chk("t2_pend_b", 32'(div_pending), 1);
        chk("t2_tick_b", 32'(tick), 0);
        step();
        chk("t2_pend_fall", 32'(div_pending), 0);
        chk("t2_tick_wrap", 32'(tick), 1);
        chk_out("t2_out_wrap", out, 1'b1);
        for (int k = 1; k <= 20; k++) begin
            step();
            chk("t2_tick10", 32'(tick), 32'(k % 10 == 0));
            chk("t2_pend0", 32'(div_pending), 0);
            chk_out("t2_out10", out, 1'((k / 10) % 2 == 0));
        end

        // back to D=4
        div_in = 8'd4; div_load = 1'b1; step(); div_load = 1'b0;
        chk("t3_pend_d4", 32'(div_pending), 1);
        repeat (8) step();
        chk("t3_tick_pre", 32'(tick), 0);
        step();
        chk("t3_tick_d4", 32'(tick), 1);
        chk("t3_pend_d4_clr", 32'(div_pending), 0);

        // two loads before wrap, last wins
        div_in = 8'd6; div_load = 1'b1; step();
        div_in = 8'd3; step(); div_load = 1'b0;
        chk("t3_pend_dbl", 32'(div_pending), 1);
        step();
        chk("t3_tick_c3", 32'(tick), 0);
        step();
        chk("t3_tick_wrap", 32'(tick), 1);
        chk("t3_pend_clr", 32'(div_pending), 0);
        chk_out("t3_out_wrap", out, 1'b1);
        for (int k = 1; k <= 6; k++) begin
            step();
            chk("t3_tick3", 32'(tick), 32'(k % 3 == 0));
        end

        // load exactly on the wrap cycle
        step(); step();
        div_in = 8'd5; div_load = 1'b1; step(); div_load = 1'b0;
        chk("t3_wrapload_pend", 32'(div_pending), 0);
        chk("t3_wrapload_tick", 32'(tick), 1);
        chk_out("t3_wrapload_out", out, 1'b0);
        for (int k = 1; k <= 5; k++) begin
            step();
            chk("t3_pend_never", 32'(div_pending), 0);
            chk("t3_tick5", 32'(tick), 32'(k == 5));
        end
        chk_out("t3_out5", out, 1'b1);

        // en low for 7 cycles at cnt=2, D=5
        step(); step();
        en = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            step();
            chk("t4_tick_frozen", 32'(tick), 0);
            chk_out("t4_out_frozen", out, 1'b1);
        end
        en = 1'b1;
        step();
        chk("t4_tick_c3", 32'(tick), 0);
        step();
        chk("t4_tick_c4", 32'(tick), 0);
        step();
        chk("t4_tick_done", 32'(tick), 1);
        chk_out("t4_out_done", out, 1'b0);

        // load 0 -> halt, out forced low at that wrap
        div_in = 8'd0; div_load = 1'b1; step(); div_load = 1'b0;
        chk("t5_pend0", 32'(div_pending), 1);
        step(); step(); step();
        chk("t5_tick_pre", 32'(tick), 0);
        chk("t5_pend_pre", 32'(div_pending), 1);
        step();
        chk("t5_pend_halt", 32'(div_pending), 0);
        chk("t5_out_forced", 32'(out), 0);
        for (int k = 1; k <= 4; k++) begin
            step();
            chk("t5_halt_tick", 32'(tick), 0);
            chk("t5_halt_out", 32'(out), 0);
        end

        // load 1 while halted and disabled: applies immediately
        en = 1'b0;
        div_in = 8'd1; div_load = 1'b1; step(); div_load = 1'b0;
        chk("t5_imm_pend", 32'(div_pending), 0);
        chk("t5_imm_tick", 32'(tick), 0);
        chk("t5_imm_out", 32'(out), 0);
        step();
        chk("t5_imm_en0_tick", 32'(tick), 0);
        en = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            step();
            chk("t5_d1_tick", 32'(tick), 1);
            chk_out("t5_d1_out", out, 1'(k % 2));
        end

        // async reset with a load pending
        div_in = 8'd3; div_load = 1'b1; step(); div_load = 1'b0;
        chk("t6_direct_pend", 32'(div_pending), 0);
        div_in = 8'd7; div_load = 1'b1; step(); div_load = 1'b0;
        chk("t6_pend", 32'(div_pending), 1);
        chk_out("t6_out_pre", out, 1'b1);
        #3 rst_n = 1'b0;
        #1;
        chk("t6_async_pend", 32'(div_pending), 0);
        chk("t6_async_tick", 32'(tick), 0);
        chk("t6_async_out", 32'(out), 0);
        step(); step();
        rst_n = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            chk("t6_init_tick", 32'(tick), 32'(k % 4 == 0));
            chk("t6_init_pend", 32'(div_pending), 0);
        end

`ifdef CLK_DIV_DUTY_EN
        // PWM: D=8 duty=3, then duty=9
        div_in = 8'd8; duty = 8'd3; div_load = 1'b1; step(); div_load = 1'b0;
        step(); step(); step();
        chk("d_tick_apply", 32'(tick), 1);
        hi = 0;
        for (int k = 1; k <= 16; k++) begin
            step();
            if (out) hi++;
        end
        chk("d_duty3_hi", 32'(hi), 6);
        div_in = 8'd8; duty = 8'd9; div_load = 1'b1; step(); div_load = 1'b0;
        repeat (7) step();
        hi = 0;
        for (int k = 1; k <= 16; k++) begin
            step();
            if (out) hi++;
        end
        chk("d_duty9_hi", 32'(hi), 16);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
